// File: rtl/uart_transmitter.sv
// UART transmit stage: valid/ready holding register feeding an LSB-first serialiser (start, data, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_transmitter #(
  parameter int WORD_SIZE   = 8,
  parameter int PULSE_WIDTH = 4,
  parameter int PACKET_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

`ifdef UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  localparam int PARITY_BITS = 0;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam int CNT_W = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam int IDX_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  // Catch framing parameters that would disagree with the receiver.
  if (PACKET_SIZE != WORD_SIZE + 2 + PARITY_BITS) begin : g_bad_packet_size
    $error("uart_transmitter: PACKET_SIZE does not match WORD_SIZE and parity setting");
  end
  if (PULSE_WIDTH < 2) begin : g_bad_pulse_width
    $error("uart_transmitter: PULSE_WIDTH must be at least 2");
  end

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic [WORD_SIZE-1:0] hold_q;
  logic                 hold_full_q;
  logic                 tx_q, tx_d;
  logic                 baud_end;
  logic                 last_bit;
  logic                 load;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign baud_end = (baud_cnt_q == CNT_W'(PULSE_WIDTH - 1));
  assign last_bit = (bit_idx_q == IDX_W'(WORD_SIZE - 1));
  // The shifter takes the held word either from idle or on the final stop clock,
  // which is what makes back-to-back frames gapless.
  assign load     = hold_full_q && ((state_q == IDLE) || ((state_q == STOP) && baud_end));

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    tx_d       = 1'b1;

    if (state_q != IDLE) begin
      baud_cnt_d = baud_end ? '0 : baud_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: ;
      START: if (baud_end) state_d = DATA;
      DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          if (last_bit) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_end) state_d = STOP;
`endif
      STOP: if (baud_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d  = START;
      shift_d  = hold_q;
`ifdef UART_TX_PARITY_EN
      parity_d = ^hold_q;
`endif
    end

    // The line is registered, so decode the level for the state being entered.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
      if (load) begin
        hold_full_q <= 1'b0;
      end else if (tx_valid && !hold_full_q) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end
    end
  end

  assign tx       = tx_q;
  assign tx_ready = !hold_full_q;
  assign tx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter: random and directed words checked against a frame-level line model.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_transmitter;

  localparam int WS = 8;
  localparam int PW = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PS = WS + 3;
`else
  localparam int PS = WS + 2;
`endif

  logic          clk;
  logic          rst;
  logic [WS-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx;
  logic          tx_busy;

  int            errors;
  int            checks;
  int            frames_done;
  int            idle_cnt;
  int            last_gap;
  int            bit_pos;
  bit            in_frame;
  logic [WS-1:0] cur_word;
  logic [PS-1:0] cur_frame;
  logic [WS-1:0] exp_q[$];

  uart_transmitter #(
    .WORD_SIZE  (WS),
    .PULSE_WIDTH(PW),
    .PACKET_SIZE(PS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line levels of one frame, bit 0 first on the wire.
  function automatic logic [PS-1:0] frame_bits(input logic [WS-1:0] w);
    logic [PS-1:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < WS; i++) f[i+1] = w[i];
`ifdef UART_TX_PARITY_EN
    f[WS+1] = ^w;
`endif
    f[PS-1] = 1'b1;
    return f;
  endfunction

  // Watches the line every clock: idle must be high and not busy, each frame must match the next accepted word.
  task automatic monitor_line();
    forever begin
      @(negedge clk);
      if (!in_frame) begin
        if (tx === 1'b0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL spurious_frame: tx=%b with no word pending, expected tx=1", tx);
          end else begin
            cur_word  = exp_q.pop_front();
            cur_frame = frame_bits(cur_word);
            in_frame  = 1'b1;
            bit_pos   = 0;
            last_gap  = idle_cnt;
          end
        end else begin
          idle_cnt++;
          checks++;
          if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_line: tx=%b busy=%b, expected tx=1 busy=0", tx, tx_busy);
          end
        end
      end
      if (in_frame) begin
        checks++;
        if (tx !== cur_frame[bit_pos/PW] || tx_busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL frame_bit: word=%h clk=%0d tx=%b busy=%b, expected tx=%b busy=1",
                   cur_word, bit_pos, tx, tx_busy, cur_frame[bit_pos/PW]);
        end
        bit_pos++;
        if (bit_pos == PS * PW) begin
          in_frame = 1'b0;
          idle_cnt = 0;
          frames_done++;
        end
      end
      if (rst === 1'b1) begin
        in_frame = 1'b0;
        idle_cnt = 0;
        exp_q.delete();
      end
    end
  endtask

  // Offers one word and returns just after the accepting edge.
  task automatic send_word(input logic [WS-1:0] w, input bit keep_valid);
    bit accepted;
    accepted = 1'b0;
    @(posedge clk);
    #1;
    tx_data  = w;
    tx_valid = 1'b1;
    for (int i = 0; i < 300 && !accepted; i++) begin
      @(negedge clk);
      if (tx_ready === 1'b1) begin
        exp_q.push_back(w);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (!keep_valid) begin
      tx_valid = 1'b0;
      tx_data  = WS'($urandom);
    end
    checks++;
    if (!accepted) begin
      errors++;
      $display("[TB] FAIL accept_timeout: word=%h accepted=%b, expected 1", w, accepted);
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frames_done < target) begin
      errors++;
      $display("[TB] FAIL frame_timeout: frames=%0d, expected %0d", frames_done, target);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (tx !== 1'b1)       begin errors++; $display("[TB] FAIL reset_tx: tx=%b, expected 1", tx); end
    if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: ready=%b, expected 1", tx_ready); end
    if (tx_busy !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy: busy=%b, expected 0", tx_busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    int base;
    base = frames_done;
    send_word(8'h55, 1'b0);
    @(negedge clk);
    checks += 2;
    if (tx !== 1'b1)       begin errors++; $display("[TB] FAIL latency_idle: tx=%b, expected 1", tx); end
    if (tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL latency_full: ready=%b, expected 0", tx_ready); end
    @(negedge clk);
    checks += 2;
    if (tx !== 1'b0)       begin errors++; $display("[TB] FAIL latency_start: tx=%b, expected 0", tx); end
    if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL latency_drain: ready=%b, expected 1", tx_ready); end
    wait_frames(base + 1, 100);
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_end: tx=%b busy=%b, expected tx=1 busy=0", tx, tx_busy);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = frames_done;
    send_word(8'hA3, 1'b0);
    send_word(8'h7E, 1'b0);
    wait_frames(base + 2, 200);
    checks++;
    if (last_gap !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_gap: idle clocks=%0d, expected 0", last_gap);
    end
  endtask

  task automatic test_backpressure();
    int base;
    logic [WS-1:0] words[3];
    words = '{8'h00, 8'hFF, 8'hC3};
    base  = frames_done;
    for (int i = 0; i < 3; i++) begin
      send_word(words[i], i != 2);
      @(negedge clk);
      checks++;
      if (tx_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_ready: word=%h ready=%b, expected 0", words[i], tx_ready);
      end
    end
    wait_frames(base + 3, 400);
    repeat (PS * PW) @(negedge clk);
    checks++;
    if (frames_done !== base + 3) begin
      errors++;
      $display("[TB] FAIL bp_count: frames=%0d, expected %0d", frames_done, base + 3);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    int n;
    base = frames_done;
    send_word(8'h3C, 1'b0);
    send_word(8'hE7, 1'b0);
    n = 0;
    while (!(in_frame && bit_pos >= 14) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (tx !== 1'b1)       begin errors++; $display("[TB] FAIL midreset_tx: tx=%b, expected 1", tx); end
    if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: ready=%b, expected 1", tx_ready); end
    if (tx_busy !== 1'b0)  begin errors++; $display("[TB] FAIL midreset_busy: busy=%b, expected 0", tx_busy); end
    if (frames_done !== base) begin
      errors++;
      $display("[TB] FAIL midreset_frames: frames=%0d, expected %0d", frames_done, base);
    end
    send_word(8'h5A, 1'b0);
    wait_frames(base + 1, 100);
  endtask

  task automatic test_random();
    int base;
    logic [WS-1:0] words[10];
    words = '{8'h55, 8'hA3, 8'h7E, 8'h00, 8'hFF, 8'hC3, 8'h3C, 8'h5A, 8'h81, 8'h1E};
    base  = frames_done;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(50, 1)) @(posedge clk);
      send_word((i < 10) ? words[i] : WS'($urandom), 1'b0);
    end
    wait_frames(base + 20, 2000);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int base;
    base = frames_done;
    send_word(8'h07, 1'b0);
    send_word(8'h81, 1'b0);
    wait_frames(base + 2, 200);
  endtask
`endif

  initial begin
    errors      = 0;
    checks      = 0;
    frames_done = 0;
    idle_cnt    = 0;
    last_gap    = -1;
    bit_pos     = 0;
    in_frame    = 1'b0;
    test_reset();
    fork
      monitor_line();
    join_none
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
